wb_arbiter_rr: RTL and testbench
================================

Name: wb_arbiter_rr

Overview:
- N-master bus arbiter for a single shared Wishbone slave, such as the SSRAM controller.
- Replaces the fixed two-master (cpu/vga) arbiter.
- Supports round-robin or fixed-priority selection, registered one-hot grants and a per-grant burst limit so one master cannot starve the others.
- Sits between the masters' cycle requests and the slave's cyc/stb/ack.
- The top level muxes adr/we/sel/dat using gnt_o.

Parameters:
- NMASTERS, 4, number of requesting masters (2..16).
- FIXED_PRIO, 0, 0 = round-robin; 1 = fixed priority with master 0 highest.
- BURST_MAX, 4, acks a master may take per grant while others wait; 0 = unlimited.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- sysclock  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- cyc_i  in  NMASTERS  per-master bus request; held high for the whole transaction
- ack_i  in  1  slave acknowledge
- cyc_o  out  1  cycle to slave; high while any grant is active
- gnt_o  out  NMASTERS  one-hot grant, registered
- gnt_idx_o  out  $clog2(NMASTERS)  index of the current/last owner
- timeout_o  out  1  one-cycle pulse on watchdog release

Behaviour:
- Reset: the clock is sysclock; rst_i is asynchronous and active-high. When asserted:
  - cyc_o=0, gnt_o=0, gnt_idx_o=0, timeout_o=0.
  - Round-robin pointer = NMASTERS-1, so master 0 wins first.
  - ack counter = 0, state = IDLE.
  - Reset mid-transaction drops the grant immediately (asynchronously).
- State IDLE:
  - If |cyc_i at a sysclock edge, select the winner. gnt_o, gnt_idx_o and cyc_o are registered at that edge and go to GRANT.
  - Latency from request to grant is 1 cycle.
  - If no request, stay in IDLE.
- Winner selection:
  - FIXED_PRIO=1: lowest-index requester wins.
  - FIXED_PRIO=0: first requester found searching upward from pointer+1, wrapping modulo NMASTERS. The pointer is set to the winner's index when the grant is issued.
- State GRANT:
  - Hold the grant while cyc_i[owner]=1.
  - Each cycle with ack_i=1 increments the ack counter (saturating).
  - ack_i while in IDLE is ignored.
- Release from GRANT to IDLE, evaluated at the edge:
  - (a) cyc_i[owner]=0; or
  - (b) BURST_MAX!=0, ack_i=1, counter+1==BURST_MAX, and another master is requesting.
- On release:
  - gnt_o=0 and cyc_o=0 for exactly one cycle; the counter clears.
  - The next arbitration happens on the following edge.
  - This dead cycle lets the slave see cyc fall between owners.
- Burst-limit edge cases:
  - Burst limit reached with no other requester: keep the grant and restart the counter at 0.
  - Burst-forced release with the owner still requesting: the owner competes normally. In round-robin it goes last; in fixed priority it may win again.
- Simultaneous events:
  - Owner drop and another master's new request in the same cycle: release, then arbitrate next cycle. There is no same-cycle handover.
  - A request arriving during the dead cycle is considered at the next edge.
- Invariants:
  - gnt_o is always one-hot or zero; cyc_o == |gnt_o.
  - gnt_idx_o holds its value while in IDLE.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A counter runs in GRANT and clears on each ack_i.
  - On reaching TIMEOUT_CYCLES-1 without an ack, force release exactly as in (b). This happens even with no other requester.
  - timeout_o pulses 1 cycle, coincident with the release; gnt_idx_o keeps the offender's index.
- When undefined: no counter is built, timeout_o is tied 0, and TIMEOUT_CYCLES is ignored.

Decomposition:
- Shared package arb_pkg:
  - state typedef arb_state_t {ARB_IDLE, ARB_GRANT};
  - function clog2_min1 (ensures width ≥1).
- One natural sub-module: rr_pick. It is combinational, taking requests, pointer and FIXED_PRIO and returning one-hot plus index. It is reused later by the interrupt controller.

Test Plan:
- Reset, then cyc_i=4'b0100 → after 1 cycle gnt_o=4'b0100, gnt_idx_o=2, cyc_o=1. Drop cyc_i → gnt_o=0 next cycle.
- FIXED_PRIO=0, cyc_i=4'b1111 held, single-ack transactions (each master drops cyc after its ack) → grant order 0,1,2,3,0 with one idle cycle between grants.
- BURST_MAX=4:
  - master 1 continuous with master 3 requesting → master 1 released after its 4th ack; gnt_o=4'b1000 two cycles later.
  - same case with master 3 idle → master 1 retains the grant past 8 acks.
- FIXED_PRIO=1, cyc_i=4'b1010 → master 1 granted. Master 0 requests mid-grant → no preemption; master 0 granted after master 1 releases, ahead of master 3.
- rst_i pulsed mid-grant → gnt_o and cyc_o go 0 before the next edge; first grant after reset goes to master 0 when cyc_i=4'b1111.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, master 2 granted with no ack_i → release at cycle 16; timeout_o=1 for one cycle; gnt_idx_o=2.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared arbiter definitions.
//   arb_state_t : IDLE / GRANT state of the bus arbiter FSM
//   clog2_min1  : $clog2 that never returns less than 1, for index/counter widths
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner picker, round-robin or fixed priority.
//   req     in  N   request vector
//   ptr     in  IW  last winner; round-robin search starts at ptr+1
//   gnt_oh  out N   one-hot winner (zero when no request)
//   gnt_idx out IW  winner index (zero when no request)
// With FIXED_PRIO=1 the pointer is ignored and the lowest index wins.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N          = 4,
  parameter int FIXED_PRIO = 0,
  parameter int IW         = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx
);

  int   c;
  logic found;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    c       = 0;
    for (int i = 0; i < N; i++) begin
      c = (FIXED_PRIO != 0) ? i : ((int'(ptr) + 1 + i) % N);
      if (!found && req[c]) begin
        found     = 1'b1;
        gnt_oh[c] = 1'b1;
        gnt_idx   = IW'(c);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_rr.sv
// N-master Wishbone arbiter in front of a single shared slave.
//   sysclock   in   clock
//   rst_i      in   async reset, active high
//   cyc_i      in   per-master cycle request, held for the whole transaction
//   ack_i      in   slave acknowledge
//   cyc_o      out  cycle to slave, equals |gnt_o
//   gnt_o      out  registered one-hot grant
//   gnt_idx_o  out  index of current / last owner (held while idle)
//   timeout_o  out  one-cycle pulse when the watchdog forces a release
// Optional macro ARB_TIMEOUT_EN builds the no-ack watchdog; without it
// timeout_o is tied low and TIMEOUT_CYCLES only feeds the config check.
// Every release inserts one dead cycle (cyc_o low) before the next grant.
module wb_arbiter_rr
  import arb_pkg::*;
#(
  parameter int NMASTERS       = 4,
  parameter int FIXED_PRIO     = 0,
  parameter int BURST_MAX      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        sysclock,
  input  logic                        rst_i,
  input  logic [NMASTERS-1:0]         cyc_i,
  input  logic                        ack_i,
  output logic                        cyc_o,
  output logic [NMASTERS-1:0]         gnt_o,
  output logic [$clog2(NMASTERS)-1:0] gnt_idx_o,
  output logic                        timeout_o
);

  localparam int IW = clog2_min1(NMASTERS);
  localparam int CW = clog2_min1(BURST_MAX + 1);

  if (NMASTERS < 2 || NMASTERS > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("wb_arbiter_rr: unsupported NMASTERS/TIMEOUT_CYCLES");
  end

  arb_state_t          state;
  logic [IW-1:0]       ptr;
  logic [CW-1:0]       cnt;
  logic [NMASTERS-1:0] pick_oh;
  logic [IW-1:0]       pick_idx;

  rr_pick #(.N(NMASTERS), .FIXED_PRIO(FIXED_PRIO), .IW(IW)) u_pick (
    .req     (cyc_i),
    .ptr     (ptr),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx)
  );

  logic owner_req, others_req, burst_end, burst_hit, wd_hit, rel;

  assign owner_req  = cyc_i[gnt_idx_o];
  assign others_req = |(cyc_i & ~gnt_o);
  assign burst_end  = (BURST_MAX != 0) && ((int'(cnt) + 1) == BURST_MAX);
  // Burst limit only forces a release when someone else is waiting.
  assign burst_hit  = ack_i && burst_end && others_req;
  assign rel        = (state == ARB_GRANT) && (!owner_req || burst_hit || wd_hit);

`ifdef ARB_TIMEOUT_EN
  localparam int WW = clog2_min1(TIMEOUT_CYCLES);
  logic [WW-1:0] wd;

  assign wd_hit = (state == ARB_GRANT) && !ack_i && (int'(wd) == TIMEOUT_CYCLES - 1);

  always_ff @(posedge sysclock or posedge rst_i) begin
    if (rst_i) begin
      wd        <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (state != ARB_GRANT || ack_i || rel) wd <= '0;
      else                                    wd <= wd + 1'b1;
      // A plain owner drop on the same edge is an ordinary release.
      timeout_o <= wd_hit && owner_req;
    end
  end
`else
  assign wd_hit    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge sysclock or posedge rst_i) begin
    if (rst_i) begin
      state     <= ARB_IDLE;
      gnt_o     <= '0;
      gnt_idx_o <= '0;
      ptr       <= IW'(NMASTERS - 1);
      cnt       <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|cyc_i) begin
            gnt_o     <= pick_oh;
            gnt_idx_o <= pick_idx;
            ptr       <= pick_idx;
            cnt       <= '0;
            state     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (rel) begin
            gnt_o <= '0;
            cnt   <= '0;
            state <= ARB_IDLE;
          end else if (ack_i) begin
            // Limit reached with nobody waiting: keep going, new burst window.
            if (burst_end)       cnt <= '0;
            else if (cnt != '1)  cnt <= cnt + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign cyc_o = |gnt_o;

endmodule

// File: tb/tb_wb_arbiter_rr.sv
module tb_wb_arbiter_rr;

  logic       sysclock = 1'b0;
  logic       rst_i    = 1'b1;
  logic [3:0] rr_cyc = '0, fp_cyc = '0;
  logic       rr_ack = 1'b0, fp_ack = 1'b0;
  logic       rr_cyc_o, fp_cyc_o, rr_to, fp_to;
  logic [3:0] rr_gnt, fp_gnt;
  logic [1:0] rr_idx, fp_idx;

  int total = 0;
  int bad   = 0;

  always #5 sysclock = ~sysclock;

  wb_arbiter_rr #(.NMASTERS(4), .FIXED_PRIO(0), .BURST_MAX(4), .TIMEOUT_CYCLES(16)) u_rr (
    .sysclock(sysclock), .rst_i(rst_i), .cyc_i(rr_cyc), .ack_i(rr_ack),
    .cyc_o(rr_cyc_o), .gnt_o(rr_gnt), .gnt_idx_o(rr_idx), .timeout_o(rr_to));

  wb_arbiter_rr #(.NMASTERS(4), .FIXED_PRIO(1), .BURST_MAX(4), .TIMEOUT_CYCLES(16)) u_fp (
    .sysclock(sysclock), .rst_i(rst_i), .cyc_i(fp_cyc), .ack_i(fp_ack),
    .cyc_o(fp_cyc_o), .gnt_o(fp_gnt), .gnt_idx_o(fp_idx), .timeout_o(fp_to));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclock);
    #1;
  endtask

  task automatic pulse_reset();
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] e;
    // reset state
    #12;
    chk("rst_gnt", rr_gnt, 0);
    chk("rst_cyc", rr_cyc_o, 0);
    chk("rst_idx", rr_idx, 0);
    chk("rst_to", rr_to, 0);
    chk("rst_fp_gnt", fp_gnt, 0);
    rst_i = 1'b0;

    // single request, one-cycle latency, drop releases
    rr_cyc = 4'b0100; tick();
    chk("t1_gnt", rr_gnt, 4'b0100);
    chk("t1_idx", rr_idx, 2);
    chk("t1_cyc", rr_cyc_o, 1);
    rr_cyc = 4'b0000; tick();
    chk("t1_drop_gnt", rr_gnt, 0);
    chk("t1_drop_cyc", rr_cyc_o, 0);
    tick();
    chk("t1_idx_hold", rr_idx, 2);

    // round-robin order 0,1,2,3,0 with a dead cycle between owners
    pulse_reset();
    rr_cyc = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      e = 4'b0001 << (k % 4);
      tick();
      chk($sformatf("rr_order%0d", k), rr_gnt, e);
      rr_ack = 1'b1; tick();
      rr_ack = 1'b0; rr_cyc = 4'b1111 & ~e; tick();
      chk($sformatf("rr_dead%0d", k), rr_cyc_o, 0);
      rr_cyc = 4'b1111;
    end
    rr_cyc = 4'b0000; tick(); tick();
    chk("rr_idle", rr_gnt, 0);

    // burst limit with master 3 waiting (pointer=0 -> master 1 wins)
    rr_cyc = 4'b1010; tick();
    chk("b_gnt1", rr_gnt, 4'b0010);
    rr_ack = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("b_hold3", rr_gnt, 4'b0010);
    tick();
    chk("b_rel4", rr_gnt, 0);
    rr_ack = 1'b0; tick();
    chk("b_m3", rr_gnt, 4'b1000);
    chk("b_m3_idx", rr_idx, 3);
    rr_cyc = 4'b0000; tick(); tick();

    // burst limit with nobody waiting: grant kept past 8 acks
    rr_cyc = 4'b0010; tick();
    chk("bn_gnt", rr_gnt, 4'b0010);
    rr_ack = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk($sformatf("bn_keep%0d", k), rr_gnt, 4'b0010);
    end
    rr_ack = 1'b0; rr_cyc = 4'b0000; tick();
    chk("bn_drop", rr_gnt, 0);

    // async reset mid-grant, then master 0 wins first
    rr_cyc = 4'b1111; tick();
    chk("r_pre", rr_gnt, 4'b0100);
    rst_i = 1'b1; #1;
    chk("r_async_gnt", rr_gnt, 0);
    chk("r_async_cyc", rr_cyc_o, 0);
    rst_i = 1'b0; tick();
    chk("r_first", rr_gnt, 4'b0001);
    rr_cyc = 4'b0000; tick(); tick();

    // fixed priority: no preemption, m0 beats m3 after release
    fp_cyc = 4'b1010; tick();
    chk("fp_m1", fp_gnt, 4'b0010);
    fp_cyc = 4'b1011; tick();
    chk("fp_nopre", fp_gnt, 4'b0010);
    fp_cyc = 4'b1001; tick();
    chk("fp_rel", fp_gnt, 0);
    tick();
    chk("fp_m0", fp_gnt, 4'b0001);
    chk("fp_m0_idx", fp_idx, 0);
    // burst-forced release: m0 still requesting wins again in fixed prio
    fp_ack = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("fp_bhold", fp_gnt, 4'b0001);
    tick();
    chk("fp_brel", fp_gnt, 0);
    fp_ack = 1'b0; tick();
    chk("fp_again", fp_gnt, 4'b0001);
    fp_cyc = 4'b1000; tick();
    chk("fp_rel2", fp_gnt, 0);
    tick();
    chk("fp_m3", fp_gnt, 4'b1000);
    fp_cyc = 4'b0000; tick();
    chk("fp_end", fp_gnt, 0);

    // no-ack grant: watchdog (if built) releases on the 16th edge
    pulse_reset();
    rr_cyc = 4'b0100; tick();
    chk("wd_gnt", rr_gnt, 4'b0100);
    for (int k = 0; k < 15; k++) tick();
    chk("wd_hold15", rr_gnt, 4'b0100);
    chk("wd_to15", rr_to, 0);
    tick();
`ifdef ARB_TIMEOUT_EN
    chk("wd_rel", rr_gnt, 0);
    chk("wd_pulse", rr_to, 1);
    chk("wd_idx", rr_idx, 2);
    tick();
    chk("wd_pulse_end", rr_to, 0);
    chk("wd_regrant", rr_gnt, 4'b0100);
`else
    chk("wd_nowd_gnt", rr_gnt, 4'b0100);
    chk("wd_nowd_to", rr_to, 0);
    for (int k = 0; k < 8; k++) tick();
    chk("wd_nowd_to2", rr_to, 0);
    chk("wd_nowd_gnt2", rr_gnt, 4'b0100);
`endif
    chk("fp_to_quiet", fp_to, 0);
    rr_cyc = 4'b0000; tick();
    chk("wd_end", rr_cyc_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
